series_result_collector: RTL and testbench
==========================================

// Module: series_result_collector
// PURPOSE
//  Sink end of the Q1.31 series-evaluation pipeline: accepts {sum, x, overflow, i} from the last slice stage
//  under valid/ready, checks the stage index, optionally saturates overflowed sums, and buffers results in a
//  small FIFO for a downstream consumer. It provides the backpressure (in_ready) that the pipeline feeder uses.
// PARAMETERS
//  DEPTH   4       FIFO entries; power of two, >= 2
//  EXP_I   3'b000  index value a completed evaluation must carry (3-bit wrap after the final slice)
//  CNT_W   8       width of the overflow event counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      pipeline result present
//  in_ready      out  1      collector can accept this cycle
//  in_sum        in   32     signed Q1.31 accumulated sum
//  in_x          in   32     signed Q1.31 argument that produced the sum
//  in_overflow   in   1      sticky overflow from any slice
//  in_i          in   3      stage index after the last slice
//  out_valid     out  1      FIFO head valid
//  out_ready     in   1      consumer takes head this cycle
//  out_sum       out  32     head sum (saturated when SATURATE_EN is defined)
//  out_x         out  32     head argument
//  out_overflow  out  1      head overflow flag
//  err_sticky    out  1      set on any accepted entry with in_i != EXP_I
//  ovf_count     out  CNT_W  count of accepted entries with in_overflow=1; saturates at all-ones
//  clr           in   1      synchronous clear of err_sticky and ovf_count
// BEHAVIOUR
//  - Reset: rd/wr pointers, occupancy, err_sticky, ovf_count = 0; out_valid=0; out_sum/out_x/out_overflow=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Both take effect at the same clock edge.
//  - in_ready = (count != DEPTH); depends only on state (no combinational path from out_ready).
//    It can read 1 while rst_n is low; no write occurs during reset.
//  - out_valid = (count != 0). out_* show mem[rd_ptr] when valid and are forced to 0 when empty.
//  - Latency: an entry pushed at edge k is visible on out_* after edge k (1 cycle); no bypass when empty.
//  - Push and pop in the same cycle: count is unchanged and both pointers advance.
//    When full, in_ready=0, so push is blocked even if pop occurs.
//  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  - Producer holds data stable while in_valid & !in_ready. Consumer holds out_ready semantics per cycle.
//  - On push: if in_i != EXP_I then err_sticky <= 1; the entry is still stored.
//    If in_overflow then ovf_count++ (holds at max).
//  - clr in the same cycle as a flagging push: clr wins, so both stats read 0 next cycle.
//  - Asserting rst_n low mid-stream discards all entries immediately (asynchronous).
// CONFIGURATION
//  SATURATE_EN defined: on push with in_overflow=1, the stored sum is 32'h7FFF_FFFF if in_sum[31]=1
//    (wrapped negative implies true positive), else 32'h8000_0000. Non-overflow sums are stored raw.
//  SATURATE_EN undefined: in_sum is stored unmodified and out_overflow alone flags validity.
// STRUCTURE
//  - series_pkg: Q1.31 constants QMAX=32'h7FFF_FFFF and QMIN=32'h8000_0000, DATA_W=32, IDX_W=3,
//    and the FIFO entry typedef {overflow, x, sum} (65 bits).
//  - Sub-module series_fifo (DEPTH, W=65): storage, pointers, count, full/empty.
//    The top level holds the index check, saturation, stats and output masking.
// TESTING
//  1. Reset then 4 pushes (sum=1..4, i=0), out_ready=0 -> in_ready=0 after the 4th; drain -> out_sum 1,2,3,4 in order.
//  2. Full FIFO, in_valid=1, out_ready=1 for one cycle -> one pop, no push; count=3, in_ready=1 next cycle.
//  3. Count=2, push and pop every cycle for 10 cycles -> count stays 2, order preserved across pointer wrap.
//  4. Push i=3'b101 -> err_sticky=1 next cycle; assert clr -> 0. Push with in_overflow=1 x300 -> ovf_count=255.
//  5. SATURATE_EN: push sum=32'h8000_0010 with ovf=1 -> out_sum=32'h7FFF_FFFF; without it -> 32'h8000_0010.
//  6. rst_n low for half a cycle with 3 entries stored -> out_valid=0 and out_sum=0 immediately; stats 0.

Source files
------------

// File: rtl/series_pkg.sv
// Shared types and Q1.31 constants for the series-evaluation result collector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package series_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;

  localparam logic [DATA_W-1:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] QMIN = 32'h8000_0000;

  // One FIFO entry, 65 bits: {overflow, x, sum}
  typedef struct packed {
    logic              overflow;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] sum;
  } entry_t;

  // A wrapped sum with the sign bit set means the true value overflowed upward.
  function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W-1:0] s);
    return s[DATA_W-1] ? QMAX : QMIN;
  endfunction

endpackage

// File: rtl/series_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy count, full/empty.
// Latency: a word written at edge k is readable on rd_dat_o after edge k; no bypass.
// Backpressure: full_o depends only on the stored count; caller must not push when full.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   push_i      write wr_dat_i this edge
//   pop_i       advance read pointer this edge
//   wr_dat_i    write data (W bits)
//   rd_dat_o    word at the read pointer (undefined contents when empty)
//   full_o      count == DEPTH
//   empty_o     count == 0
module series_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wr_dat_i,
  output logic [W-1:0] rd_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/series_result_collector.sv
// Sink of the Q1.31 series pipeline: index check, optional saturation, stats, output FIFO.
// Latency: 1 cycle from accepted input to out_valid; no bypass when empty.
// Backpressure: in_ready = FIFO not full, registered state only (no path from out_ready).
//
// Optional feature macro: SATURATE_EN (saturate overflowed sums before storing).
//
// Ports:
//   clk, rst_n                          clock / asynchronous active-low reset
//   in_valid/in_ready                   input handshake
//   in_sum, in_x, in_overflow, in_i     result from the last slice stage
//   out_valid/out_ready                 output handshake (FIFO head)
//   out_sum, out_x, out_overflow        head entry, zero when empty
//   err_sticky                          an accepted entry carried in_i != EXP_I
//   ovf_count                           accepted overflowed entries, saturating
//   clr                                 synchronous clear of err_sticky and ovf_count
module series_result_collector
  import series_pkg::*;
#(
  parameter int               DEPTH = 4,
  parameter logic [IDX_W-1:0] EXP_I = 3'b000,
  parameter int               CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic [DATA_W-1:0] in_x,
  input  logic              in_overflow,
  input  logic [IDX_W-1:0]  in_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [DATA_W-1:0] out_x,
  output logic              out_overflow,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  ovf_count,
  input  logic              clr
);

  logic   push, pop, full, empty;
  entry_t wr_entry, head;

  logic             err_q, err_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_entry.overflow = in_overflow;
    wr_entry.x        = in_x;
`ifdef SATURATE_EN
    wr_entry.sum      = in_overflow ? sat_sum(in_sum) : in_sum;
`else
    wr_entry.sum      = in_sum;
`endif
  end

  series_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .wr_dat_i (wr_entry),
    .rd_dat_o (head),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Stats: clr takes priority over a flagging push in the same cycle.
  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr) begin
      err_d = 1'b0;
      ovf_d = '0;
    end else if (push) begin
      if (in_i != EXP_I)                 err_d = 1'b1;
      if (in_overflow && (ovf_q != '1))  ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign err_sticky = err_q;
  assign ovf_count  = ovf_q;

  // Stale storage is hidden while the FIFO is empty.
  assign out_sum      = out_valid ? head.sum      : '0;
  assign out_x        = out_valid ? head.x        : '0;
  assign out_overflow = out_valid ? head.overflow : 1'b0;

endmodule

// File: tb/tb_series_result_collector.sv
module tb_series_result_collector;
  import series_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_sum = '0, in_x = '0;
  logic        in_overflow = 1'b0;
  logic [2:0]  in_i = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_sum, out_x;
  logic        out_overflow, err_sticky;
  logic [7:0]  ovf_count;
  logic        clr = 1'b0;

  series_result_collector #(.DEPTH(DEPTH), .EXP_I(3'b000), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_x(in_x), .in_overflow(in_overflow), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_x(out_x), .out_overflow(out_overflow),
    .err_sticky(err_sticky), .ovf_count(ovf_count), .clr(clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Scoreboard and reference model state
  entry_t     sb[$];
  logic       m_err = 1'b0;
  logic [7:0] m_ovf = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic entry_t expect_entry(input logic [31:0] s, input logic [31:0] x, input logic ovf);
    entry_t e;
    e.overflow = ovf;
    e.x        = x;
    e.sum      = s;
`ifdef SATURATE_EN
    if (ovf) e.sum = s[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] s, input logic ovf,
                       input logic [2:0] i, input logic ordy, input logic c);
    in_valid = v; in_sum = s; in_x = s ^ 32'hA5A5_0000; in_overflow = ovf;
    in_i = i; out_ready = ordy; clr = c;
  endtask

  // Check outputs against the model, advance the model by one edge, then step the clock.
  task automatic tick();
    bit acc, pp;
    int cnt;
    cnt = sb.size();
    chk("in_ready", {31'b0, in_ready}, {31'b0, cnt != DEPTH});
    chk("out_valid", {31'b0, out_valid}, {31'b0, cnt != 0});
    if (cnt != 0) begin
      chk("out_sum", out_sum, sb[0].sum);
      chk("out_x", out_x, sb[0].x);
      chk("out_overflow", {31'b0, out_overflow}, {31'b0, sb[0].overflow});
    end else begin
      chk("out_sum_empty", out_sum, 32'h0);
      chk("out_x_empty", out_x, 32'h0);
    end
    chk("err_sticky", {31'b0, err_sticky}, {31'b0, m_err});
    chk("ovf_count", {24'b0, ovf_count}, {24'b0, m_ovf});
    acc = in_valid && (cnt != DEPTH);
    pp  = out_ready && (cnt != 0);
    if (pp)  void'(sb.pop_front());
    if (acc) sb.push_back(expect_entry(in_sum, in_x, in_overflow));
    if (clr) begin
      m_err = 1'b0; m_ovf = '0;
    end else if (acc) begin
      if (in_i != 3'b000) m_err = 1'b1;
      if (in_overflow && m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] sum;
    logic        ovf;
    logic [2:0]  i;
    logic        ordy;
    logic        c;
    logic        e_ir;
    logic        e_ov;
    logic        e_err;
    logic [7:0]  e_ovc;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mkv(input logic v, input logic [31:0] s, input logic ovf, input logic [2:0] i,
                               input logic ordy, input logic c, input logic e_ir, input logic e_ov,
                               input logic e_err, input logic [7:0] e_ovc);
    vec_t r;
    r.v = v; r.sum = s; r.ovf = ovf; r.i = i; r.ordy = ordy; r.c = c;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_err = e_err; r.e_ovc = e_ovc;
    return r;
  endfunction

  initial begin
    //            v  sum ovf i     rdy clr | ir ov err ovc   (expected after the edge)
    tbl[0]  = mkv(1, 1,  0, 3'd0, 0,  0,    1, 1, 0, 0);
    tbl[1]  = mkv(1, 2,  0, 3'd0, 0,  0,    1, 1, 0, 0);
    tbl[2]  = mkv(1, 3,  0, 3'd0, 0,  0,    1, 1, 0, 0);
    tbl[3]  = mkv(1, 4,  0, 3'd0, 0,  0,    0, 1, 0, 0);  // full
    tbl[4]  = mkv(1, 5,  0, 3'd0, 1,  0,    1, 1, 0, 0);  // full: pop only, count 3
    tbl[5]  = mkv(1, 5,  0, 3'd0, 1,  0,    1, 1, 0, 0);  // push+pop, count 3
    tbl[6]  = mkv(0, 0,  0, 3'd0, 1,  0,    1, 1, 0, 0);  // count 2
    tbl[7]  = mkv(1, 6,  1, 3'd5, 0,  0,    1, 1, 1, 1);  // bad index + overflow
    tbl[8]  = mkv(1, 7,  1, 3'd0, 0,  1,    0, 1, 0, 0);  // clr beats flagging push
    tbl[9]  = mkv(0, 0,  0, 3'd0, 1,  0,    1, 1, 0, 0);
    tbl[10] = mkv(0, 0,  0, 3'd0, 1,  0,    1, 1, 0, 0);
    tbl[11] = mkv(0, 0,  0, 3'd0, 1,  0,    1, 1, 0, 0);
    tbl[12] = mkv(0, 0,  0, 3'd0, 1,  0,    1, 0, 0, 0);  // drained

    // Reset state
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_err", {31'b0, err_sticky}, 32'd0);
    chk("rst_ovf", {24'b0, ovf_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: fill, full backpressure, push+pop when full, stats and clr priority, drain
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].v, tbl[k].sum, tbl[k].ovf, tbl[k].i, tbl[k].ordy, tbl[k].c);
      tick();
      chk($sformatf("tbl%0d_in_ready", k), {31'b0, in_ready}, {31'b0, tbl[k].e_ir});
      chk($sformatf("tbl%0d_out_valid", k), {31'b0, out_valid}, {31'b0, tbl[k].e_ov});
      chk($sformatf("tbl%0d_err", k), {31'b0, err_sticky}, {31'b0, tbl[k].e_err});
      chk($sformatf("tbl%0d_ovf", k), {24'b0, ovf_count}, {24'b0, tbl[k].e_ovc});
    end

    // Steady state at count 2 across pointer wrap
    drive(1, 32'h100, 0, 3'd0, 0, 0); tick();
    drive(1, 32'h101, 0, 3'd0, 0, 0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h200 + k, 0, 3'd0, 1, 0);
      tick();
      chk("wrap_count2", {30'b0, in_ready, out_valid}, 32'd3);
    end
    chk("wrap_head", out_sum, 32'h208);
    drive(0, 0, 0, 3'd0, 1, 0); tick(); tick();

    // Index error sticky and clear
    drive(1, 32'h11, 0, 3'b101, 0, 0); tick();
    chk("err_set", {31'b0, err_sticky}, 32'd1);
    drive(0, 0, 0, 3'd0, 1, 1); tick();
    chk("err_clr", {31'b0, err_sticky}, 32'd0);

    // Overflow counter saturation
    for (int k = 0; k < 300; k++) begin
      drive(1, k, 1, 3'd0, 1, 0);
      tick();
    end
    chk("ovf_sat", {24'b0, ovf_count}, 32'd255);
    drive(0, 0, 0, 3'd0, 1, 0); tick();

    // Saturation of a wrapped-negative overflowed sum
    drive(1, 32'h8000_0010, 1, 3'd0, 0, 0); tick();
`ifdef SATURATE_EN
    chk("sat_sum", out_sum, 32'h7FFF_FFFF);
`else
    chk("sat_sum", out_sum, 32'h8000_0010);
`endif
    drive(0, 0, 0, 3'd0, 1, 1); tick();

    // Asynchronous reset mid-stream with 3 stored entries and non-zero stats
    drive(1, 32'h31, 1, 3'd2, 0, 0); tick();
    drive(1, 32'h32, 0, 3'd0, 0, 0); tick();
    drive(1, 32'h33, 0, 3'd0, 0, 0); tick();
    drive(0, 0, 0, 3'd0, 0, 0);
    chk("pre_rst_stats", {30'b0, err_sticky, ovf_count[0]}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_sum", out_sum, 32'd0);
    chk("arst_err", {31'b0, err_sticky}, 32'd0);
    chk("arst_ovf", {24'b0, ovf_count}, 32'd0);
    #4 rst_n = 1'b1;
    sb.delete(); m_err = 1'b0; m_ovf = '0;
    @(posedge clk); #1;
    drive(1, 32'h44, 0, 3'd0, 0, 0); tick();
    drive(0, 0, 0, 3'd0, 1, 0); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
